// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Shared UART definitions used by both the transmitter and the receiver:
// FSM state encodings, the default bit period and the 8N1 frame constants.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_tx_pkg;

    // Line FSM states; the encodings are shared with the receiver.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

    // 50 MHz board clock / 9600 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 5208;

    // The bit-period counter is 13 bits, which covers CLKS_PER_BIT up to 8191.
    localparam int CNT_WIDTH = 13;

    // 8N1 frame constants.
    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if
// Host-side handshake of the UART transmitter.
//   start  : write strobe, pushes in_tx into the transmit buffer
//   in_tx  : byte to transmit
//   full   : transmit buffer holds FIFO_DEPTH bytes
//   busy   : a frame is on the line
//   done   : one-cycle pulse when a frame's stop bit has completed
// master = host driving bytes in, slave = the transmitter.
// -----------------------------------------------------------------------------
interface uart_tx_if;
    import uart_tx_pkg::*;

    logic                 start;
    logic [DATA_BITS-1:0] in_tx;
    logic                 full;
    logic                 busy;
    logic                 done;

    modport master (
        output start,
        output in_tx,
        input  full,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  in_tx,
        output full,
        output busy,
        output done
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous first-word-fall-through FIFO used as the transmit buffer.
//   clk   : clock
//   reset : asynchronous active-high reset, empties the buffer
//   push  : write din (ignored while full)
//   pop   : discard the head entry (ignored while empty)
//   din   : write data
//   dout  : head entry, valid whenever empty is low
//   full  : DEPTH entries held
//   empty : no entries held
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DATA_BITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // full is taken from the registered count, i.e. before any pop this cycle,
    // so a push into a full buffer is dropped even when a pop happens alongside.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign dout = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Buffered 8N1 UART transmitter: bytes written through the host interface are
// queued in uart_tx_fifo and sent LSB first, one start bit and one stop bit,
// each bit lasting CLKS_PER_BIT clocks.
//   clk       : board clock
//   reset     : asynchronous active-high reset, aborts any frame and empties
//               the buffer
//   bus       : host handshake (start, in_tx, full, busy, done)
//   output_tx : serial line, idles high, driven straight from a flop
// -----------------------------------------------------------------------------
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic      clk,
    input  logic      reset,
    uart_tx_if.slave  bus,
    output logic      output_tx
);

    localparam int                    BIT_W      = $clog2(DATA_BITS);
    localparam logic [CNT_WIDTH-1:0]  LAST_COUNT = CNT_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]      LAST_BIT   = BIT_W'(DATA_BITS - 1);

    uart_state_t            state;
    logic [CNT_WIDTH-1:0]   count;
    logic [BIT_W-1:0]       bit_idx;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   tx_reg;
    logic                   busy_reg;
    logic                   done_reg;

    logic [DATA_BITS-1:0]   fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;

    // The head byte is taken only from IDLE, so a frame in flight lives
    // entirely in shift_reg and later pushes cannot disturb it.
    assign fifo_pop = (state == IDLE) && !fifo_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.start),
        .pop   (fifo_pop),
        .din   (bus.in_tx),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.full  = fifo_full;
    assign bus.busy  = busy_reg;
    assign bus.done  = done_reg;
    assign output_tx = tx_reg;

    // Line FSM. tx_reg always carries the level of the bit being sent, so it
    // is loaded on the same edge as the state change that starts that bit.
    // done is raised on the STOP->IDLE edge, which leaves one idle-high cycle
    // before a queued byte can start its frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx_reg    <= STOP_BIT;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    count   <= '0;
                    bit_idx <= '0;
                    if (!fifo_empty) begin
                        shift_reg <= fifo_dout;
                        state     <= START;
                        tx_reg    <= START_BIT;
                        busy_reg  <= 1'b1;
                    end else begin
                        tx_reg   <= STOP_BIT;
                        busy_reg <= 1'b0;
                    end
                end

                START: begin
                    if (count == LAST_COUNT) begin
                        count   <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx_reg  <= shift_reg[0];
                    end else begin
                        count <= count + 1'b1;
                    end
                end

                DATA: begin
                    if (count == LAST_COUNT) begin
                        count <= '0;
                        if (bit_idx == LAST_BIT) begin
                            state  <= STOP;
                            tx_reg <= STOP_BIT;
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= shift_reg >> 1;
                            tx_reg    <= shift_reg[1];
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end

                STOP: begin
                    if (count == LAST_COUNT) begin
                        count    <= '0;
                        state    <= IDLE;
                        done_reg <= 1'b1;
                        busy_reg <= 1'b0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    count    <= '0;
                    bit_idx  <= '0;
                    tx_reg   <= STOP_BIT;
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule
